// File: rtl/sdc_rx_pkg.sv
// Shared types and constants for the SD card D0 read-data receiver.
// Holds the receiver state encoding and the bit-serial CRC16 step.
package sdc_rx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_START,
      DATA,
      CRC,
      END_BIT,
      DONE
   } rx_state_e;

   localparam logic [15:0] CRC16_POLY    = 16'h1021;
   localparam int unsigned DEF_BLK_BYTES = 512;
   localparam int unsigned DEF_DATA_WD   = 64;
   localparam int unsigned CRC_BITS      = 16;

   // One bit of CRC16 (x^16+x^12+x^5+1), MSB-first
   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
      logic fb;
      fb = crc[15] ^ din;
      return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/sdc_crc16_ser.sv
// Bit-serial CRC16 accumulator, one bit per enabled clock, zero initial value.
module sdc_crc16_ser
   import sdc_rx_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic        en,
   input  logic        bit_in,
   output logic [15:0] crc
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         crc <= 16'h0000;
      end else if (clr) begin
         crc <= 16'h0000;
      end else if (en) begin
         crc <= crc16_step(crc, bit_in);
      end
   end

endmodule

// File: rtl/sdc_dat_rx.sv
// Single-block SD D0 read receiver: start bit, 512-byte payload into words, CRC16, end bit.
// CRC checking is present only when SDC_RX_CRC_CHK_EN is defined; otherwise crc_err is 0.
module sdc_dat_rx
   import sdc_rx_pkg::*;
#(
   parameter int unsigned BLK_BYTES = DEF_BLK_BYTES,
   parameter int unsigned DATA_WD   = DEF_DATA_WD,
   parameter logic [15:0] TMO_CYC   = 16'hFFFF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               sd_smp_strb,
   input  logic               strt_rd_strb,
   input  logic               abort_strb,
   input  logic               D0_in,
   output logic [DATA_WD-1:0] rd_dat,
   output logic               rd_dat_vld,
   input  logic               rd_dat_ack,
   output logic [6:0]         wrd_cnt,
   output logic               busy,
   output logic               blk_done_strb,
   output logic               crc_err,
   output logic               end_bit_err,
   output logic               tmo_err,
   output logic               ovr_err
);

   localparam int unsigned BLK_BITS = BLK_BYTES * 8;
   localparam int unsigned BCNT_W   = $clog2(BLK_BITS);
   localparam int unsigned WB_W     = $clog2(DATA_WD);
   localparam int unsigned CCNT_W   = $clog2(CRC_BITS);

   rx_state_e            state;
   logic [15:0]          tmo_cnt;
   logic [BCNT_W-1:0]    bit_cnt;
   logic [CCNT_W-1:0]    crc_cnt;
   logic [DATA_WD-2:0]   shreg;
   logic [DATA_WD-1:0]   word_c;
   logic                 word_end_c;
   logic                 last_bit_c;
   logic                 last_crc_c;
   logic                 tmo_hit_c;

   // Shift register keeps only the first DATA_WD-1 bits; the live bit completes the word
   assign word_c     = {shreg, D0_in};
   assign word_end_c = &bit_cnt[WB_W-1:0];
   assign last_bit_c = (bit_cnt == BCNT_W'(BLK_BITS - 1));
   assign last_crc_c = (crc_cnt == CCNT_W'(CRC_BITS - 1));
   assign tmo_hit_c  = (tmo_cnt == (TMO_CYC - 16'd1));

`ifdef SDC_RX_CRC_CHK_EN
   logic [CRC_BITS-1:0] rx_crc;
   logic [15:0]         calc_crc;
   logic                crc_err_q;

   sdc_crc16_ser u_crc (
      .clk    (clk),
      .reset  (reset),
      .clr    ((state == IDLE) && strt_rd_strb),
      .en     ((state == DATA) && sd_smp_strb),
      .bit_in (D0_in),
      .crc    (calc_crc)
   );

   assign crc_err = crc_err_q;
`else
   assign crc_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         tmo_cnt       <= 16'h0000;
         bit_cnt       <= '0;
         crc_cnt       <= '0;
         shreg         <= '0;
         rd_dat        <= '0;
         rd_dat_vld    <= 1'b0;
         wrd_cnt       <= 7'd0;
         busy          <= 1'b0;
         blk_done_strb <= 1'b0;
         end_bit_err   <= 1'b0;
         tmo_err       <= 1'b0;
         ovr_err       <= 1'b0;
`ifdef SDC_RX_CRC_CHK_EN
         rx_crc        <= '0;
         crc_err_q     <= 1'b0;
`endif
      end else begin
         blk_done_strb <= 1'b0;

         // Consumer handshake; a same-cycle word load below overrides the clear
         if (rd_dat_ack && rd_dat_vld) begin
            rd_dat_vld <= 1'b0;
            wrd_cnt    <= wrd_cnt + 7'd1;
         end

         if (abort_strb) begin
            state      <= IDLE;
            busy       <= 1'b0;
            rd_dat_vld <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (strt_rd_strb) begin
                     state       <= WAIT_START;
                     busy        <= 1'b1;
                     tmo_cnt     <= 16'h0000;
                     bit_cnt     <= '0;
                     crc_cnt     <= '0;
                     wrd_cnt     <= 7'd0;
                     end_bit_err <= 1'b0;
                     tmo_err     <= 1'b0;
                     ovr_err     <= 1'b0;
`ifdef SDC_RX_CRC_CHK_EN
                     crc_err_q   <= 1'b0;
`endif
                  end
               end

               WAIT_START: begin
                  if (sd_smp_strb) begin
                     if (!D0_in) begin
                        state <= DATA;
                     end else if (tmo_hit_c) begin
                        tmo_err       <= 1'b1;
                        blk_done_strb <= 1'b1;
                        busy          <= 1'b0;
                        state         <= IDLE;
                     end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                     end
                  end
               end

               DATA: begin
                  if (sd_smp_strb) begin
                     shreg   <= word_c[DATA_WD-2:0];
                     bit_cnt <= bit_cnt + BCNT_W'(1);
                     if (word_end_c) begin
                        // A word still waiting for its ack is kept; the new one is lost
                        if (!rd_dat_vld || rd_dat_ack) begin
                           rd_dat     <= word_c;
                           rd_dat_vld <= 1'b1;
                        end else begin
                           ovr_err <= 1'b1;
                        end
                     end
                     if (last_bit_c) begin
                        state <= CRC;
                     end
                  end
               end

               CRC: begin
                  if (sd_smp_strb) begin
`ifdef SDC_RX_CRC_CHK_EN
                     rx_crc  <= {rx_crc[CRC_BITS-2:0], D0_in};
`endif
                     crc_cnt <= crc_cnt + CCNT_W'(1);
                     if (last_crc_c) begin
                        state <= END_BIT;
                     end
                  end
               end

               END_BIT: begin
                  if (sd_smp_strb) begin
                     if (!D0_in) begin
                        end_bit_err <= 1'b1;
                     end
`ifdef SDC_RX_CRC_CHK_EN
                     if (calc_crc != rx_crc) begin
                        crc_err_q <= 1'b1;
                     end
`endif
                     state <= DONE;
                  end
               end

               DONE: begin
                  blk_done_strb <= 1'b1;
                  busy          <= 1'b0;
                  state         <= IDLE;
               end

               default: begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/sdc_dat_rx.md
Name: sdc_dat_rx

Overview:
- Single-block read-data receiver for the SD card D0 line; the read-direction counterpart of the host-controller write path.
- After the host issues CMD17, it waits for the start bit, deserialises 512 bytes MSB-first into 64-bit words, checks the CRC16 and the end bit, and hands the words to the PUC side.
- Sits inside sd_host_controller beside the command module; it samples D0_in on the SDC_CLK sampling strobe.

Parameters:
- BLK_BYTES, 512, bytes per block; must be a multiple of DATA_WD/8.
- DATA_WD, 64, output word width.
- TMO_CYC, 16'hFFFF, SD-clock strobes to wait for the start bit before timeout.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sd_smp_strb  in  1  one-clk strobe at each SDC_CLK sampling edge; all bit activity is qualified by it.
- strt_rd_strb  in  1  arms the receiver (after CMD17 end bit).
- abort_strb  in  1  forces return to IDLE.
- D0_in  in  1  SD data line 0.
- rd_dat  out  DATA_WD  assembled data word.
- rd_dat_vld  out  1  word valid; held until acknowledged.
- rd_dat_ack  in  1  one-clk consume strobe from PUC side.
- wrd_cnt  out  7  words delivered in current block.
- busy  out  1  high in any state other than IDLE.
- blk_done_strb  out  1  one-clk pulse when the block completes.
- crc_err  out  1  sticky until next strt_rd_strb.
- end_bit_err  out  1  sticky until next strt_rd_strb.
- tmo_err  out  1  sticky until next strt_rd_strb.
- ovr_err  out  1  sticky until next strt_rd_strb.

Behaviour:
- Reset (asynchronous): every output is 0, state is IDLE, and all counters and shift registers are 0.
- States: IDLE, WAIT_START, DATA, CRC, END_BIT, DONE.
- IDLE: on strt_rd_strb, clear the sticky errors, wrd_cnt and the CRC, then go to WAIT_START. strt_rd_strb in any other state is ignored.
- WAIT_START: on each sd_smp_strb, D0_in=0 → DATA; otherwise increment the timeout counter. When the counter reaches TMO_CYC, set tmo_err, pulse blk_done_strb, and go to IDLE.
- DATA: on each sd_smp_strb, shift D0_in into the LSB of the shift register (MSB-first) and feed the bit into the CRC16.
  - After every DATA_WD bits, the word is complete. If rd_dat_vld=0, load rd_dat and set rd_dat_vld on the next clk.
  - If rd_dat_vld=1, the new word is dropped, ovr_err is set, and rd_dat is unchanged.
  - After BLK_BYTES*8 bits → CRC.
- rd_dat_ack while rd_dat_vld=1: clear rd_dat_vld and increment wrd_cnt in the same clk. An ack while vld=0 is ignored. If ack and a new load occur in the same clk, the load wins: vld stays 1 and wrd_cnt still increments.
- CRC: shift 16 bits, MSB-first, into rx_crc; → END_BIT.
- END_BIT: on sd_smp_strb, D0_in=0 sets end_bit_err. If calc_crc != rx_crc, set crc_err. → DONE.
- DONE: pulse blk_done_strb for 1 clk; → IDLE. Only D0 is used; D1–D3 are ignored.
- CRC16: poly x^16+x^12+x^5+1, initial value 0, one bit per sd_smp_strb.
- abort_strb has priority over all transitions: go to IDLE with no blk_done_strb, clear rd_dat_vld, and keep the sticky errors.
- wrd_cnt wraps only via clear; its maximum is BLK_BYTES*8/DATA_WD = 64.

Optional Feature:
- SDC_RX_CRC_CHK_EN defined: the CRC16 is computed and compared as described above.
- Not defined: the CRC sub-module is not instantiated, the 16 CRC bits are still consumed, and crc_err is tied to 0.

Decomposition:
- Package sdc_rx_pkg:
  - state enum;
  - CRC16_POLY=16'h1021;
  - DEF_BLK_BYTES=512;
  - DEF_DATA_WD=64;
  - CRC_BITS=16.
- One sub-module, sdc_crc16_ser: serial CRC16 with clr, en and bit inputs and a 16-bit crc output. It is instantiated only under SDC_RX_CRC_CHK_EN.

Test Plan:
- Block of all 0xFF, CRC 16'h7FA1, end bit 1, ack every word within 10 clks → 64 words of 64'hFFFF_FFFF_FFFF_FFFF, wrd_cnt=64, blk_done_strb once, all errors 0.
- Incrementing bytes 0x00..0xFF repeated: the first word is 64'h0001_0203_0405_0607 → the CRC is corrupted by one flipped bit → crc_err=1, end_bit_err=0, and all 64 words are still delivered.
- D0 held high after strt_rd_strb with TMO_CYC=16 → tmo_err=1 and blk_done_strb on the 16th sd_smp_strb, busy=0 afterwards.
- Word 0 is never acked → ovr_err=1 at word 1, rd_dat stays equal to word 0, wrd_cnt=0 until ack.
- End bit driven 0 → end_bit_err=1; abort_strb mid-DATA (bit 1000) → IDLE, no blk_done_strb, rd_dat_vld=0.
- reset asserted asynchronously mid-DATA → all outputs 0 immediately; a subsequent full block is received cleanly.
